// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: accepts an operand over valid/ready, shifts one
// bit position per clock, and returns the result over a second valid/ready port.
module seq_shifter #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             busy
);

  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_LSL  = 3'b001;
  localparam logic [2:0] MODE_LSR  = 3'b010;
  localparam logic [2:0] MODE_ASR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       op;
  logic [AW-1:0]    count;
  logic [WIDTH-1:0] shift1;
  logic             accept;
  logic             mode_shifts;

  assign accept = in_valid && in_ready;

  // Pass and the two reserved encodings complete without any SHIFT cycles.
  always_comb begin
    mode_shifts = 1'b0;
    case (mode)
      MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL, MODE_ROR: mode_shifts = 1'b1;
      default:                                          mode_shifts = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((amount == AW'(0)) || !mode_shifts) state_nxt = DONE;
          else                                    state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (count == AW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // One-position step applied to the result register each SHIFT cycle.
  always_comb begin
    shift1 = sout;
    case (op)
      MODE_LSL: shift1 = {sout[WIDTH-2:0], 1'b0};
      MODE_LSR: shift1 = {1'b0, sout[WIDTH-1:1]};
      MODE_ASR: shift1 = {sout[WIDTH-1], sout[WIDTH-1:1]};
      MODE_ROL: shift1 = {sout[WIDTH-2:0], sout[WIDTH-1]};
      MODE_ROR: shift1 = {sout[0], sout[WIDTH-1:1]};
      default:  shift1 = sout;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sout  <= '0;
      op    <= MODE_PASS;
      count <= '0;
    end else if (accept) begin
      sout  <= in;
      op    <= mode;
      count <= amount;
    end else if (state == SHIFT) begin
      sout  <= shift1;
      count <= count - AW'(1);
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter at WIDTH=16: results, latency, backpressure,
// request blocking outside IDLE and asynchronous reset in mid-operation.
module tb_seq_shifter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [2:0]       mode;
  logic [AW-1:0]    amount;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  seq_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .mode      (mode),
    .amount    (amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sout      (sout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, check result latency and value, then hand the result off.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [2:0] m,
                        input logic [3:0] n, input logic [15:0] exp, input int lat);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk({tag, " ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in       = a;
    mode     = m;
    amount   = n;
    tick();
    in_valid = 1'b0;
    in       = 16'h5A5A;
    mode     = 3'b001;
    amount   = 4'd7;
    waited   = 0;
    while (!out_valid && waited < 40) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      tick();
      waited++;
    end
    chk({tag, " latency"}, 32'(waited), 32'(lat));
    chk({tag, " sout"}, 32'(sout), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " handoff out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " handoff in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " sout kept"}, 32'(sout), 32'(exp));
  endtask

  initial begin
    int waited;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in        = '0;
    mode      = '0;
    amount    = '0;
    out_ready = 1'b0;
    #12;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset sout", 32'(sout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    tick();

    run_op("lsl1",   16'hF0CF, 3'b001, 4'd1,  16'hE19E, 1);
    run_op("asr4",   16'hF0CF, 3'b011, 4'd4,  16'hFF0C, 4);
    run_op("lsr15",  16'hF0CF, 3'b010, 4'd15, 16'h0001, 15);
    run_op("rol4",   16'hF0CF, 3'b100, 4'd4,  16'h0CFF, 4);
    run_op("ror8",   16'hF0CF, 3'b101, 4'd8,  16'hCFF0, 8);
    run_op("lsl0",   16'hF0CF, 3'b001, 4'd0,  16'hF0CF, 0);
    run_op("rsvd5",  16'hF0CF, 3'b110, 4'd5,  16'hF0CF, 0);
    run_op("pass7",  16'h1234, 3'b000, 4'd7,  16'h1234, 0);
    run_op("asr15",  16'h8000, 3'b011, 4'd15, 16'hFFFF, 15);
    run_op("asrpos", 16'h7000, 3'b011, 4'd3,  16'h0E00, 3);
    run_op("lsl15",  16'h0001, 3'b001, 4'd15, 16'h8000, 15);
    run_op("ror1",   16'h0001, 3'b101, 4'd1,  16'h8000, 1);
    run_op("rol15",  16'h1234, 3'b100, 4'd15, 16'h091A, 15);

    // Backpressure: result held while out_ready is low, new request blocked.
    in_valid = 1'b1;
    in       = 16'h8001;
    mode     = 3'b010;
    amount   = 4'd2;
    tick();
    in       = 16'hFFFF;
    mode     = 3'b000;
    amount   = 4'd0;
    waited   = 0;
    while (!out_valid && waited < 40) begin
      tick();
      waited++;
    end
    chk("bp latency", 32'(waited), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("bp sout", 32'(sout), 32'h2000);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp handoff out_valid", 32'(out_valid), 32'd0);
    chk("bp handoff in_ready", 32'(in_ready), 32'd1);
    chk("bp handoff sout", 32'(sout), 32'h2000);
    tick();
    in_valid = 1'b0;
    chk("bp next accepted", 32'(out_valid), 32'd1);
    chk("bp next sout", 32'(sout), 32'hFFFF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp next handoff", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a long shift.
    in_valid = 1'b1;
    in       = 16'h8000;
    mode     = 3'b011;
    amount   = 4'd12;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid busy", 32'(busy), 32'd1);
    chk("mid sout", 32'(sout), 32'hF000);
    #2;
    reset = 1'b1;
    #1;
    chk("async sout", 32'(sout), 32'd0);
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post reset in_ready", 32'(in_ready), 32'd1);
    run_op("post lsl3", 16'h0001, 3'b001, 4'd3, 16'h0008, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised multi-cycle shift/rotate unit. It is the successor to the fixed 16-bit, 1-position combinational shifter and feeds the ALU datapath. It accepts an operand, a shift mode and a variable shift amount over a valid/ready handshake. It shifts one bit position per clock and returns the result over a second valid/ready handshake.

Parameters:
WIDTH, 16, datapath width in bits; power of 2, minimum 4.
AW, $clog2(WIDTH), width of the shift-amount field (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in  input  WIDTH  operand
mode  input  3  000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR, 110/111 reserved (treated as pass)
amount  input  AW  shift distance, 0..WIDTH-1
out_valid  output  1  sout holds a completed result
out_ready  input  1  consumer accepts result
sout  output  WIDTH  result register
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, sout=0, out_valid=0, busy=0, internal count=0. in_ready=0 while reset is high and 1 in the first cycle after release. Any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE) && !reset. out_valid = (state==DONE).
- Accept: rising edge with in_valid && in_ready.
  - sout <= in; internal mode and count <= mode, amount.
  - Next state is DONE if amount==0 or the mode is pass/reserved; otherwise SHIFT.
  - Inputs are sampled only at the accept edge; later changes to in, mode or amount have no effect.
- SHIFT: each edge applies one 1-bit operation to sout and decrements count. When count==1 at the edge, the state goes to DONE after that final shift.
  - LSL: {sout[W-2:0],0}
  - LSR: {0,sout[W-1:1]}
  - ASR: {sout[W-1],sout[W-1:1]}
  - ROL: {sout[W-2:0],sout[W-1]}
  - ROR: {sout[0],sout[W-1:1]}
- Latency: with accept at edge k and amount N, out_valid is first high after edge k+N. For N=0 or pass, it is high after edge k.
- DONE: sout and out_valid are held stable indefinitely while out_ready is low. On an edge with out_valid && out_ready, the state goes to IDLE and out_valid drops. sout keeps its value until the next accept.
- No overlap: in_valid is ignored outside IDLE. There is no result/request overlap; a new accept is possible earliest on the edge after the handoff edge.
- Result equals the combinational shift/rotate of in by N in the selected mode.
  - ASR by WIDTH-1 yields all sign bits.
  - LSR/LSL by WIDTH-1 leaves a single bit.
  - Rotate by N never loses bits.
- Count never underflows: SHIFT is never entered with count==0.
- Reset asserted mid-SHIFT or mid-DONE forces the reset values immediately, without waiting for a clock edge.

Test Plan:
- WIDTH=16, in=0xF0CF, mode=LSL, amount=1 -> out_valid after accept+1 edge, sout=0xE19E; with out_ready=1, back to IDLE (in_ready=1) next cycle.
- in=0xF0CF, ASR, amount=4 -> sout=0xFF0C after exactly 4 edges. Then LSR 15 -> sout=0x0001. Then ROL 4 -> 0x0CFF. Then ROR 8 -> 0xCFF0.
- in=0xF0CF, LSL, amount=0, and separately mode=110, amount=5 -> sout=0xF0CF, out_valid high after the accept edge, no SHIFT cycles.
- Backpressure: LSR 2 on 0x8001 with out_ready=0 for 3 cycles -> sout=0x2000 held stable and out_valid held 1. A second in_valid with in=0xFFFF is not accepted (in_ready=0). out_ready=1 -> handoff; the next request is then accepted.
- Reset mid-op: ASR 12 on 0x8000, reset asserted 3 cycles after accept -> sout=0, out_valid=0, busy=0 without a clock edge. After release, in_ready=1, and a fresh LSL 3 on 0x0001 yields 0x0008.
